// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master issues requests; the slave (the subtractor) returns results.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;

  modport master (output start, a, b, bin, input busy, done, d, bout);
  modport slave  (input start, a, b, bin, output busy, done, d, bout);
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = a - b - bin, LSB first, one bit per clock.
// An operation takes WIDTH cycles in RUN, one cycle in DONE and one in IDLE.
// d/bout are only updated on the final RUN edge, so they hold the last result.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] ra, rb, rs;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] d_q;
  logic             bout_q;

  // One full-subtractor cell working on the current LSBs.
  logic x, y, diff_bit, brw_nxt;
  assign x        = ra[0];
  assign y        = rb[0];
  assign diff_bit = x ^ y ^ brw;
  assign brw_nxt  = (~x & y) | (~(x ^ y) & brw);

  // Handshake flags decode straight from the state register.
  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.d    = d_q;
  assign bus.bout = bout_q;

  // Control FSM plus the operand, result and borrow datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ra     <= '0;
      rb     <= '0;
      rs     <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      d_q    <= '0;
      bout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            ra    <= bus.a;
            rb    <= bus.b;
            brw   <= bus.bin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          ra  <= {1'b0, ra[WIDTH-1:1]};
          rb  <= {1'b0, rb[WIDTH-1:1]};
          rs  <= {diff_bit, rs[WIDTH-1:1]};
          brw <= brw_nxt;
          if (cnt == CW'(WIDTH-1)) begin
            // Last bit: publish the completed result including this bit.
            d_q    <= {diff_bit, rs[WIDTH-1:1]};
            bout_q <= brw_nxt;
            state  <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor with hand-computed expectations.
module tb_serial_subtractor;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one operation and check the full busy/done timeline and result.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                        input logic [W-1:0] ed, input logic eb);
    @(negedge clk);
    bus.a = ia; bus.b = ib; bus.bin = ibin; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.bin = 1'($urandom);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk("busy_run", bus.busy, 1);
      chk("done_run", bus.done, 0);
    end
    @(negedge clk);
    chk("done_pulse", bus.done, 1);
    chk("busy_done", bus.busy, 0);
    chk("d", bus.d, ed);
    chk("bout", bus.bout, eb);
    @(negedge clk);
    chk("done_after", bus.done, 0);
    chk("busy_after", bus.busy, 0);
    chk("d_hold", bus.d, ed);
  endtask

  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_d", bus.d, 0);
    chk("rst_bout", bus.bout, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic results, including wrap-around and borrow-in cases.
    run_op(8'd5,   8'd6,   1'b0, 8'hFF, 1'b1);
    run_op(8'd6,   8'd5,   1'b0, 8'h01, 1'b0);
    run_op(8'd9,   8'd9,   1'b0, 8'h00, 1'b0);
    run_op(8'd9,   8'd3,   1'b0, 8'h06, 1'b0);
    run_op(8'd255, 8'd0,   1'b1, 8'hFE, 1'b0);
    run_op(8'd0,   8'd0,   1'b1, 8'hFF, 1'b1);

    // Start pulsed mid-run must be ignored.
    @(negedge clk);
    bus.a = 8'd20; bus.b = 8'd7; bus.bin = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (i == 2) begin bus.a = 8'd1; bus.b = 8'd2; bus.start = 1'b1; end
      if (i == 3) bus.start = 1'b0;
      chk("ign_busy", bus.busy, 1);
      chk("ign_done", bus.done, 0);
    end
    @(negedge clk);
    chk("ign_pulse", bus.done, 1);
    chk("ign_d", bus.d, 8'h0D);
    chk("ign_bout", bus.bout, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ign_idle_busy", bus.busy, 0);
      chk("ign_idle_done", bus.done, 0);
    end

    // Asynchronous reset in the middle of RUN aborts the operation.
    bus.a = 8'd100; bus.b = 8'd50; bus.bin = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk("pre_abort_busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_d", bus.d, 0);
    chk("abort_bout", bus.bout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", bus.done, 0);
      chk("abort_no_busy", bus.busy, 0);
    end
    run_op(8'd100, 8'd50, 1'b0, 8'h32, 1'b0);

    // Start held high: back-to-back operations every W+2 cycles.
    @(negedge clk);
    bus.a = 8'd200; bus.b = 8'd100; bus.bin = 1'b0; bus.start = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      chk("hold_busy", bus.busy, ((n % (W + 2)) < W) ? 1 : 0);
      chk("hold_done", bus.done, ((n % (W + 2)) == W) ? 1 : 0);
      if ((n % (W + 2)) == W) begin
        chk("hold_d", bus.d, 8'h64);
        chk("hold_bout", bus.bout, 0);
      end
    end
    bus.start = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial WIDTH-bit subtractor. Computes d = a - b - bin, LSB first, one bit per clock, with a start/done handshake. It is the inverse-direction companion to the team's combinational ripple adder, and it sits beside that adder in the lab datapath as the area-cheap subtract unit. It also checks the adder: for operands x and y, adder(d, y, 0) must equal x when bout = 0.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend; captured at the accepted start edge
b  input  WIDTH  subtrahend; captured at the accepted start edge
bin  input  1  borrow-in; captured at the accepted start edge
busy  output  1  high while state = RUN
done  output  1  one-cycle pulse; d and bout valid
d  output  WIDTH  difference (a - b - bin) mod 2^WIDTH, registered
bout  output  1  borrow-out; 1 iff a < b + bin (unsigned), registered

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; busy = 0, done = 0, d = 0, bout = 0; internal shift registers, borrow register and bit counter cleared.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on a rising edge with start = 1. At that edge: ra <= a, rb <= b, brw <= bin, cnt <= 0.
- IDLE with start = 0: stay in IDLE; outputs hold.
- RUN, each edge:
  - x = ra[0], y = rb[0].
  - diff bit = x ^ y ^ brw.
  - brw <= (~x & y) | (~(x ^ y) & brw).
  - ra and rb shift right by 1.
  - diff bit enters the MSB of the internal result shift register rs, which shifts right.
  - cnt <= cnt + 1.
- RUN -> DONE on the edge where cnt = WIDTH-1, i.e. after the WIDTH-th bit. At that edge: d <= final rs (including the last bit); bout <= final borrow.
- DONE -> IDLE unconditionally on the next edge.
- Latency: start accepted at edge E0 -> busy = 1 after E0 through edge E0+WIDTH -> done = 1 for exactly one cycle after edge E0+WIDTH.
  - Next start is accepted no earlier than edge E0+WIDTH+2.
  - Total WIDTH+2 cycles per operation.
- busy = (state == RUN); done = (state == DONE). Both are decoded from registered state; no combinational path from the inputs.
- start asserted in RUN or DONE is ignored. It is not queued, and the a/b/bin inputs do not disturb the operation in progress.
- a, b and bin may change freely after the accepted start edge.
- d and bout change only at the RUN -> DONE edge. They hold their value through IDLE until the next completed operation.
- Wrap-around: d is the result modulo 2^WIDTH; bout is the only overflow indication.
  - a = 0, b = 0, bin = 1 gives d = all ones, bout = 1.
- cnt is wide enough to hold WIDTH-1 and never wraps in normal operation.
- Reset asserted mid-RUN aborts the operation immediately. All outputs return to 0, and no done pulse is produced for the aborted operation.
- start held high continuously: an operation begins each time IDLE is re-entered, one every WIDTH+2 cycles.

Test Plan:
- Reset, then a=5, b=6, bin=0, start for 1 cycle -> busy for 8 cycles; done pulses once 8 cycles after the start edge; d=8'hFF, bout=1.
- a=6, b=5, bin=0 -> d=8'h01, bout=0. Then a=9, b=9 -> d=8'h00, bout=0. Then a=9, b=3 -> d=8'h06, bout=0.
- a=255, b=0, bin=1 -> d=8'hFE, bout=0. Then a=0, b=0, bin=1 -> d=8'hFF, bout=1.
- Start a=20, b=7. In cycle 3 of RUN, pulse start with a=1, b=2 -> result d=8'h0D, bout=0. Exactly one done pulse. No second operation is started; busy returns low after done.
- Start a=100, b=50. Drop rst_n for 1 cycle in RUN cycle 4 -> busy, done, d and bout go 0 immediately (asynchronously), and no done follows. Then a=100, b=50 -> d=8'h32, bout=0.
- start held high for 30 cycles with fixed a=200, b=100 -> done pulses every 10 cycles; each gives d=8'h64, bout=0. busy is low exactly in the DONE and IDLE cycles between runs.
